paddle_ctrl: RTL and testbench
==============================

// Module: paddle_ctrl
// PURPOSE
//  Two-player paddle position controller for the pong core. Consumes 1-clk cw/ccw
//  step pulses from two rotary_encoder instances, accumulates them between frames
//  and applies one clamped position update per frame_tick (VGA vsync-derived).
//  Also sequences freeze (play halted) and auto-recentre after a point is scored.
// PARAMETERS
//  POS_W      10   paddle position width (top-edge Y, unsigned)
//  POS_MIN    0    lowest legal position
//  POS_MAX    400  highest legal position (screen height - paddle height)
//  POS_INIT   200  reset / recentre target (POS_MIN <= POS_INIT <= POS_MAX)
//  STEP       8    pixels per encoder detent
//  PEND_W     4    signed pending-step accumulator width; saturates at +/-(2^(PEND_W-1)-1)
//  RC_STEP    32   max pixels moved per frame_tick while recentring
//  ACCEL_THR  4    |pending| at/above which acceleration applies (PADDLE_ACCEL_EN only)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-low reset
//  frame_tick in   1      1-clk pulse, once per frame; position update strobe
//  enable     in   1      1 = play running; 0 = freeze paddles
//  center     in   1      1-clk pulse: start recentre of both paddles
//  p1_cw      in   1      player 1 step down pulse (+1)
//  p1_ccw     in   1      player 1 step up pulse (-1)
//  p2_cw      in   1      player 2 step down pulse (+1)
//  p2_ccw     in   1      player 2 step up pulse (-1)
//  p1_pos     out  POS_W  player 1 paddle position
//  p2_pos     out  POS_W  player 2 paddle position
//  p1_moved   out  1      1-clk pulse: p1_pos changed on this update
//  p2_moved   out  1      1-clk pulse: p2_pos changed on this update
//  recentring out  1      1 while FSM in RECENTER
// BEHAVIOUR
//  Reset: p1_pos=p2_pos=POS_INIT, pending=0, moved=0, recentring=0, state FREEZE.
//  FSM (one for both players):
//   FREEZE  : pending forced to 0, pulses discarded; enable=1 -> RUN; center -> RECENTER.
//   RUN     : accumulate + update per frame; enable=0 -> FREEZE; center -> RECENTER.
//   RECENTER: encoder pulses discarded, pending held 0; on each frame_tick each pos
//             moves toward POS_INIT by min(RC_STEP, distance); when both equal
//             POS_INIT after an update -> RUN if enable else FREEZE. enable ignored here.
//   center has priority over enable; center in RECENTER restarts nothing (no-op).
//  Accumulate (RUN): per player pend += cw - ccw; cw&ccw same clk = net 0;
//   saturate at +/-(2^(PEND_W-1)-1), never wrap.
//  Update (RUN, frame_tick): delta = pend*STEP, computed signed at POS_W+PEND_W+8 bits;
//   new = clamp(pos+delta, POS_MIN, POS_MAX); pos registered same edge; pend reset to
//   this cycle's incoming step (pulse coincident with frame_tick is kept for next frame).
//  moved asserted the clk after the update edge, only if pos value changed; clamped
//   no-op updates (e.g. ccw at POS_MIN) give moved=0. Same rule in RECENTER.
//  State change and frame_tick same clk: update uses state before the edge.
//  Reset mid-operation: immediate return to reset values, no partial update.
// CONFIGURATION
//  PADDLE_ACCEL_EN defined  : if |pend| >= ACCEL_THR at update, delta = 2*pend*STEP
//                             (still clamped).
//  PADDLE_ACCEL_EN undefined: delta = pend*STEP always; ACCEL_THR unused.
// TESTING
//  1 Reset, enable=0 -> pos=200/200, moved=0, recentring=0; pulses+ticks change nothing.
//  2 enable=1, 3 p1_cw, frame_tick -> p1_pos=224, p1_moved 1 clk after tick, p2_pos=200.
//  3 10 p2_ccw, frame_tick -> pend saturates -7, p2_pos=144 (accel build: 88).
//  4 p1_pos=392, 2 cw, tick -> 400 moved=1; 1 cw, tick -> 400 moved=0; same at 0 w/ ccw.
//  5 p1_cw coincident with frame_tick, pend=0 -> no move; next tick -> +8.
//  6 p1=400,p2=0, center -> recentring=1, p1 368,336,..; p2 32,64,..; 200/200 after 7
//    ticks, pulses ignored, then RUN (enable=1) with recentring=0.

Source files
------------

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: two-player paddle position controller with freeze/recentre FSM.
// Optional build macro PADDLE_ACCEL_EN doubles large per-frame moves.
module paddle_ctrl #(
  parameter int POS_W     = 10,
  parameter int POS_MIN   = 0,
  parameter int POS_MAX   = 400,
  parameter int POS_INIT  = 200,
  parameter int STEP      = 8,
  parameter int PEND_W    = 4,
  parameter int RC_STEP   = 32,
  parameter int ACCEL_THR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic             center,
  input  logic             p1_cw,
  input  logic             p1_ccw,
  input  logic             p2_cw,
  input  logic             p2_ccw,
  output logic [POS_W-1:0] p1_pos,
  output logic [POS_W-1:0] p2_pos,
  output logic             p1_moved,
  output logic             p2_moved,
  output logic             recentring
);

  localparam int DW   = POS_W + PEND_W + 8;
  localparam int PMAX = 2 ** (PEND_W - 1) - 1;

  localparam logic signed [PEND_W:0] SMAX =
    (PEND_W + 1)'(PMAX);
  localparam logic signed [PEND_W:0] SMIN = -SMAX;
  localparam logic signed [DW-1:0] LO = DW'(POS_MIN);
  localparam logic signed [DW-1:0] HI = DW'(POS_MAX);
  localparam logic [POS_W-1:0] INIT = POS_W'(POS_INIT);
  localparam logic [POS_W-1:0] RCS  = POS_W'(RC_STEP);
`ifdef PADDLE_ACCEL_EN
  localparam logic signed [PEND_W-1:0] ATHR =
    PEND_W'(ACCEL_THR);
`endif

  typedef enum logic [1:0] {
    FREEZE,
    RUN,
    RECENTER
  } state_e;

  state_e state_q, state_d;

  logic [POS_W-1:0] p1_pos_q, p1_pos_d;
  logic [POS_W-1:0] p2_pos_q, p2_pos_d;
  logic signed [PEND_W-1:0] p1_pend_q, p1_pend_d;
  logic signed [PEND_W-1:0] p2_pend_q, p2_pend_d;
  logic p1_moved_q, p1_moved_d;
  logic p2_moved_q, p2_moved_d;

  function automatic logic signed [PEND_W-1:0] acc(
    input logic signed [PEND_W-1:0] p,
    input logic                     up,
    input logic                     dn
  );
    logic signed [PEND_W:0] s;
    s = $signed({p[PEND_W-1], p});
    unique case (1'b1)
      up && !dn: s = s + (PEND_W + 1)'(1);
      dn && !up: s = s - (PEND_W + 1)'(1);
      default:   s = s;
    endcase
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    return s[PEND_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] upd(
    input logic [POS_W-1:0]         pos,
    input logic signed [PEND_W-1:0] pend
  );
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] s;
    d = $signed(DW'(pend)) * $signed(DW'(STEP));
`ifdef PADDLE_ACCEL_EN
    if (pend >= ATHR || pend <= -ATHR) d = d <<< 1;
`endif
    s = $signed(DW'(pos)) + d;
    if (s < LO) return POS_W'(POS_MIN);
    if (s > HI) return POS_W'(POS_MAX);
    return s[POS_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] rc(
    input logic [POS_W-1:0] pos
  );
    if (pos > INIT)
      return (pos - INIT > RCS) ? pos - RCS : INIT;
    return (INIT - pos > RCS) ? pos + RCS : INIT;
  endfunction

  // Next state, accumulation and per-frame position update.
  always_comb begin
    state_d   = state_q;
    p1_pos_d  = p1_pos_q;
    p2_pos_d  = p2_pos_q;
    p1_pend_d = p1_pend_q;
    p2_pend_d = p2_pend_q;
    unique case (state_q)
      FREEZE: begin
        if (center)      state_d = RECENTER;
        else if (enable) state_d = RUN;
      end
      RUN: begin
        if (frame_tick) begin
          p1_pos_d  = upd(p1_pos_q, p1_pend_q);
          p2_pos_d  = upd(p2_pos_q, p2_pend_q);
          p1_pend_d = acc('0, p1_cw, p1_ccw);
          p2_pend_d = acc('0, p2_cw, p2_ccw);
        end else begin
          p1_pend_d = acc(p1_pend_q, p1_cw, p1_ccw);
          p2_pend_d = acc(p2_pend_q, p2_cw, p2_ccw);
        end
        if (center)       state_d = RECENTER;
        else if (!enable) state_d = FREEZE;
      end
      RECENTER: begin
        if (frame_tick) begin
          p1_pos_d = rc(p1_pos_q);
          p2_pos_d = rc(p2_pos_q);
          if (p1_pos_d == INIT && p2_pos_d == INIT)
            state_d = enable ? RUN : FREEZE;
        end
      end
      default: state_d = FREEZE;
    endcase
    if (state_d != RUN) begin
      p1_pend_d = '0;
      p2_pend_d = '0;
    end
    p1_moved_d = (p1_pos_d != p1_pos_q);
    p2_moved_d = (p2_pos_d != p2_pos_q);
  end

  // State, position, pending and moved registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FREEZE;
      p1_pos_q   <= INIT;
      p2_pos_q   <= INIT;
      p1_pend_q  <= '0;
      p2_pend_q  <= '0;
      p1_moved_q <= 1'b0;
      p2_moved_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_pos_q   <= p1_pos_d;
      p2_pos_q   <= p2_pos_d;
      p1_pend_q  <= p1_pend_d;
      p2_pend_q  <= p2_pend_d;
      p1_moved_q <= p1_moved_d;
      p2_moved_q <= p2_moved_d;
    end
  end

  assign p1_pos     = p1_pos_q;
  assign p2_pos     = p2_pos_q;
  assign p1_moved   = p1_moved_q;
  assign p2_moved   = p2_moved_q;
  assign recentring = (state_q == RECENTER);

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: scoreboard bench for paddle_ctrl.
// Reference model works on plain ints per frame rule.
module tb_paddle_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic frame_tick, enable, center;
  logic p1_cw, p1_ccw, p2_cw, p2_ccw;
  logic [9:0] p1_pos, p2_pos;
  logic p1_moved, p2_moved, recentring;

  always #5 clk = ~clk;

  paddle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (enable),
    .center     (center),
    .p1_cw      (p1_cw),
    .p1_ccw     (p1_ccw),
    .p2_cw      (p2_cw),
    .p2_ccw     (p2_ccw),
    .p1_pos     (p1_pos),
    .p2_pos     (p2_pos),
    .p1_moved   (p1_moved),
    .p2_moved   (p2_moved),
    .recentring (recentring)
  );

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] b;
    logic       ma;
    logic       mb;
    logic       rc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  localparam int M_FRZ = 0;
  localparam int M_RUN = 1;
  localparam int M_RC  = 2;

  int mp[2];
  int mpend[2];
  int mmv[2];
  int mmode;

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int mini(int x, int y);
    return (x < y) ? x : y;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mp[i] = 200; mpend[i] = 0; mmv[i] = 0;
    end
    mmode = M_FRZ;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.a  = mp[0][9:0];
    e.b  = mp[1][9:0];
    e.ma = (mmv[0] != 0);
    e.mb = (mmv[1] != 0);
    e.rc = (mmode == M_RC);
    q.push_back(e);
  endfunction

  function automatic void model_step(
    bit ft, bit en, bit ce,
    bit c0, bit w0, bit c1, bit w1
  );
    int s[2];
    int d, np;
    s[0] = int'(c0) - int'(w0);
    s[1] = int'(c1) - int'(w1);
    for (int i = 0; i < 2; i++) begin
      mmv[i] = 0;
      np = mp[i];
      if (mmode == M_RUN) begin
        if (ft) begin
          d = mpend[i] * 8;
`ifdef PADDLE_ACCEL_EN
          if (mpend[i] >= 4 || mpend[i] <= -4) d = 2 * d;
`endif
          np = clampi(mp[i] + d, 0, 400);
          mpend[i] = s[i];
        end else begin
          mpend[i] = clampi(mpend[i] + s[i], -7, 7);
        end
      end else if (mmode == M_RC && ft) begin
        if (mp[i] > 200) np = mp[i] - mini(32, mp[i] - 200);
        else             np = mp[i] + mini(32, 200 - mp[i]);
      end
      mmv[i] = (np != mp[i]) ? 1 : 0;
      mp[i] = np;
    end
    case (mmode)
      M_FRZ: mmode = ce ? M_RC : (en ? M_RUN : M_FRZ);
      M_RUN: mmode = ce ? M_RC : (en ? M_RUN : M_FRZ);
      default:
        if (ft && mp[0] == 200 && mp[1] == 200)
          mmode = en ? M_RUN : M_FRZ;
    endcase
    if (mmode != M_RUN) begin
      mpend[0] = 0; mpend[1] = 0;
    end
  endfunction

  // Monitor: compare every presented output against the queue.
  always @(negedge clk) begin
    exp_t e, got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = '{p1_pos, p2_pos, p1_moved, p2_moved, recentring};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL sb t=%0t got p1=%0d p2=%0d m=%b%b rc=%b exp p1=%0d p2=%0d m=%b%b rc=%b",
          $time, got.a, got.b, got.ma, got.mb, got.rc,
          e.a, e.b, e.ma, e.mb, e.rc);
      end
    end
  end

  task automatic chk(string nm, int act, int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, want);
    end
  endtask

  task automatic cyc(
    bit ft, bit en, bit ce,
    bit c0, bit w0, bit c1, bit w1
  );
    frame_tick = ft; enable = en; center = ce;
    p1_cw = c0; p1_ccw = w0; p2_cw = c1; p2_ccw = w1;
    model_step(ft, en, ce, c0, w0, c1, w1);
    push_exp();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    frame_tick = 0; enable = 0; center = 0;
    p1_cw = 0; p1_ccw = 0; p2_cw = 0; p2_ccw = 0;
    rst = 1'b0;
    model_reset();
    push_exp();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic bit rb(int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  initial begin
    do_reset();
    repeat (4) cyc(1, 0, 0, 1, 0, 1, 1);
    chk("frz_p1", p1_pos, 200);
    chk("frz_p2", p2_pos, 200);
    chk("frz_rc", recentring, 0);
    chk("frz_mv", p1_moved, 0);

    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("run_p1", p1_pos, 224);
    chk("run_mv", p1_moved, 1);
    chk("run_p2", p2_pos, 200);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("mv_pulse", p1_moved, 0);

    repeat (10) cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
`ifdef PADDLE_ACCEL_EN
    chk("sat_p2", p2_pos, 88);
`else
    chk("sat_p2", p2_pos, 144);
`endif

    repeat (7) begin
      repeat (3) cyc(0, 1, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
    end
    chk("p1_392", p1_pos, 392);
    repeat (2) cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("clmp_hi", p1_pos, 400);
    chk("clmp_hi_mv", p1_moved, 1);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("noop_hi", p1_pos, 400);
    chk("noop_hi_mv", p1_moved, 0);

    repeat (17) begin
      repeat (3) cyc(0, 1, 0, 0, 1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
    end
    chk("clmp_lo", p1_pos, 0);
    chk("clmp_lo_mv", p1_moved, 1);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("noop_lo", p1_pos, 0);
    chk("noop_lo_mv", p1_moved, 0);

    cyc(1, 1, 0, 1, 0, 0, 0);
    chk("coin_p1", p1_pos, 0);
    chk("coin_mv", p1_moved, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("coin_next", p1_pos, 8);

    repeat (20) begin
      repeat (3) cyc(0, 1, 0, 1, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 0, 0);
    end
    chk("pre_rc_p1", p1_pos, 400);
    chk("pre_rc_p2", p2_pos, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("rc_on", recentring, 1);
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 1, 0, rb(2), rb(2), rb(2), rb(2));
      cyc(1, 1, 0, rb(2), rb(2), rb(2), rb(2));
      chk("rc_p1", p1_pos, (k < 7) ? 400 - 32 * k : 200);
      chk("rc_p2", p2_pos, (k < 7) ? 32 * k : 200);
    end
    chk("rc_off", recentring, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc(rb(8), !rb(16), rb(64),
          rb(3), rb(3), rb(3), rb(3));
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
